// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
//   Shared definitions for the Whac-A-Mole game controller:
//     - game_state_t : encoded sequencer state, also driven out for display
//     - width helpers used to size the remaining-time and score buses
// ---------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READY  = 3'd1,
    PLAY   = 3'd2,
    PAUSED = 3'd3,
    OVER   = 3'd4
  } game_state_t;

  // $clog2 that never returns a zero width, so degenerate parameter values
  // still produce legal vectors.
  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

  // Width of the remaining-time bus (milliseconds over the whole game).
  function automatic int time_width(input int game_length_seconds);
    return clog2_min1(1000 * game_length_seconds);
  endfunction

  // Width needed to hold 0..max_score.
  function automatic int score_width(input int max_score);
    return clog2_min1(max_score + 1);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// ---------------------------------------------------------------------------
// rise_detect
//   One-cycle rising-edge detector for an already debounced, synchronous
//   level: o_rise = i_level & ~(i_level delayed by one clock).
// Ports
//   clk      in  clock
//   rst      in  synchronous active-high reset (clears the history flop)
//   i_level  in  synchronous level input
//   o_rise   out high for the first cycle i_level is seen high
// ---------------------------------------------------------------------------
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_rise
);

  logic r_level_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_level_q <= 1'b0;
    else     r_level_q <= i_level;
  end

  assign o_rise = i_level & ~r_level_q;

endmodule

// File: rtl/game_controller.sv
// ---------------------------------------------------------------------------
// game_controller
//   Whac-A-Mole sequencer and scorer. Runs IDLE -> READY -> PLAY -> OVER with
//   pause/resume and abort, drives the countdown timer's reset/enable, keeps
//   the current score and the best score since reset.
// Ports
//   clk, rst            clock; synchronous active-high reset
//   i_start_btn         level; rising edge = start / restart / abort
//   i_pause_btn         level; rising edge = pause / resume toggle
//   i_hit_pulse         1-cycle pulse, mole hit
//   i_miss_pulse        1-cycle pulse, miss
//   i_time_ms           remaining game time from the timer (0 = expired)
//   o_timer_rst         hold the timer in reset (IDLE/READY/OVER)
//   o_timer_enable      let the timer count (PLAY only)
//   o_game_state        encoded game_state_t
//   o_score             current score
//   o_high_score        best score since reset
//   o_game_over_pulse   one cycle on entry to OVER
//   o_new_high_score    high during OVER when this game beat the high score
// ---------------------------------------------------------------------------
module game_controller
  import game_pkg::*;
#(
  parameter  int GAME_LENGTH_SECONDS = 20,
  parameter  int CLKS_PER_MS         = 50000,
  parameter  int READY_MS            = 3000,
  parameter  int MAX_SCORE           = 999,
  parameter  int MISS_PENALTY        = 1,
  localparam int TIME_W              = time_width(GAME_LENGTH_SECONDS),
  localparam int SCORE_W             = score_width(MAX_SCORE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start_btn,
  input  logic               i_pause_btn,
  input  logic               i_hit_pulse,
  input  logic               i_miss_pulse,
  input  logic [TIME_W-1:0]  i_time_ms,
  output logic               o_timer_rst,
  output logic               o_timer_enable,
  output logic [2:0]         o_game_state,
  output logic [SCORE_W-1:0] o_score,
  output logic [SCORE_W-1:0] o_high_score,
  output logic               o_game_over_pulse,
  output logic               o_new_high_score
);

  localparam int PRESC_W = clog2_min1(CLKS_PER_MS);
  localparam int MS_W    = clog2_min1(READY_MS + 1);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLKS_PER_MS - 1);
  localparam logic [MS_W-1:0]    MS_LAST    = MS_W'(READY_MS - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = SCORE_W'(MAX_SCORE);

  logic               w_start_rise;
  logic               w_pause_rise;
  logic               w_ready_done;
  logic               w_enter_ready;
  logic               w_enter_over;
  game_state_t        w_state_next;
  logic [SCORE_W-1:0] w_score_next;

  game_state_t        r_state;
  logic [PRESC_W-1:0] r_presc;
  logic [MS_W-1:0]    r_ms;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] r_high_score;
  logic               r_timer_rst;
  logic               r_timer_enable;
  logic               r_game_over_pulse;
  logic               r_new_high_score;

  rise_detect u_start_rise (
    .clk     (clk),
    .rst     (rst),
    .i_level (i_start_btn),
    .o_rise  (w_start_rise)
  );

  rise_detect u_pause_rise (
    .clk     (clk),
    .rst     (rst),
    .i_level (i_pause_btn),
    .o_rise  (w_pause_rise)
  );

  // Last cycle of the READY hold: final clock of the final millisecond.
  assign w_ready_done = (r_presc == PRESC_LAST) && (r_ms == MS_LAST);

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start_rise) w_state_next = READY;
      READY:   if (w_ready_done) w_state_next = PLAY;
      // Expiry outranks pause; start is ignored while playing.
      PLAY: begin
        if (i_time_ms == '0)   w_state_next = OVER;
        else if (w_pause_rise) w_state_next = PAUSED;
      end
      // Abort outranks resume when both buttons rise together.
      PAUSED: begin
        if (w_start_rise)      w_state_next = IDLE;
        else if (w_pause_rise) w_state_next = PLAY;
      end
      OVER:    if (w_start_rise) w_state_next = READY;
      default: w_state_next = IDLE;
    endcase
  end

  // Score update. Saturation is tested before the +1/-1 so the SCORE_W-wide
  // arithmetic can never wrap. A hit and miss in the same cycle cancel out.
  always_comb begin
    w_score_next = r_score;
    case (r_state)
      IDLE: if (w_start_rise) w_score_next = '0;
      PLAY: begin
        if (i_hit_pulse && !i_miss_pulse) begin
          if (r_score != SCORE_MAX) w_score_next = r_score + SCORE_W'(1);
        end else if (i_miss_pulse && !i_hit_pulse && (MISS_PENALTY != 0)) begin
          if (r_score != '0) w_score_next = r_score - SCORE_W'(1);
        end
      end
      OVER: if (w_start_rise) w_score_next = '0;
      default: w_score_next = r_score;
    endcase
  end

  assign w_enter_ready = (w_state_next == READY) && (r_state != READY);
  assign w_enter_over  = (r_state == PLAY) && (w_state_next == OVER);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= IDLE;
      r_presc           <= '0;
      r_ms              <= '0;
      r_score           <= '0;
      r_high_score      <= '0;
      r_timer_rst       <= 1'b1;
      r_timer_enable    <= 1'b0;
      r_game_over_pulse <= 1'b0;
      r_new_high_score  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_score <= w_score_next;

      // Timer controls are decoded from the next state so they change on the
      // same edge as the state register.
      r_timer_rst    <= (w_state_next != PLAY) && (w_state_next != PAUSED);
      r_timer_enable <= (w_state_next == PLAY);

      r_game_over_pulse <= w_enter_over;

      // The final score (including a hit on the expiry cycle) is compared
      // at the PLAY->OVER edge, so the flag and high score are valid in the
      // first OVER cycle alongside the pulse.
      if (w_enter_over) begin
        if (w_score_next > r_high_score) begin
          r_high_score     <= w_score_next;
          r_new_high_score <= 1'b1;
        end else begin
          r_new_high_score <= 1'b0;
        end
      end else if (w_state_next != OVER) begin
        r_new_high_score <= 1'b0;
      end

      // READY hold: prescaler counts clocks per ms, r_ms counts ms.
      if (w_enter_ready) begin
        r_presc <= '0;
        r_ms    <= '0;
      end else if (r_state == READY) begin
        if (r_presc == PRESC_LAST) begin
          r_presc <= '0;
          r_ms    <= r_ms + MS_W'(1);
        end else begin
          r_presc <= r_presc + PRESC_W'(1);
        end
      end
    end
  end

  assign o_game_state      = r_state;
  assign o_score           = r_score;
  assign o_high_score      = r_high_score;
  assign o_timer_rst       = r_timer_rst;
  assign o_timer_enable    = r_timer_enable;
  assign o_game_over_pulse = r_game_over_pulse;
  assign o_new_high_score  = r_new_high_score;

endmodule

// File: tb/tb_game_controller.sv
// ---------------------------------------------------------------------------
// tb_game_controller
//   Two controllers share one stimulus stream: dut_a with miss penalty on,
//   dut_b with it off. A behavioural model (integer score arithmetic plus an
//   expected-state sequence written out step by step) supplies every
//   expected value. The bench also plays the countdown timer on i_time_ms.
// ---------------------------------------------------------------------------
module tb_game_controller;
  import game_pkg::*;

  localparam int GLS      = 20;
  localparam int CPM      = 4;
  localparam int RMS      = 3;
  localparam int MAXS     = 7;
  localparam int TW       = time_width(GLS);
  localparam int SW       = score_width(MAXS);
  localparam int TMS_INIT = 5000;
  localparam int READY_CYCLES = CPM * RMS;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_btn, pause_btn, hit, miss;
  logic [TW-1:0] time_ms;

  logic          a_trst, a_ten, a_pulse, a_nh;
  logic [2:0]    a_state;
  logic [SW-1:0] a_score, a_high;
  logic          b_trst, b_ten, b_pulse, b_nh;
  logic [2:0]    b_state;
  logic [SW-1:0] b_score, b_high;

  game_controller #(
    .GAME_LENGTH_SECONDS(GLS), .CLKS_PER_MS(CPM), .READY_MS(RMS),
    .MAX_SCORE(MAXS), .MISS_PENALTY(1)
  ) dut_a (
    .clk(clk), .rst(rst), .i_start_btn(start_btn), .i_pause_btn(pause_btn),
    .i_hit_pulse(hit), .i_miss_pulse(miss), .i_time_ms(time_ms),
    .o_timer_rst(a_trst), .o_timer_enable(a_ten), .o_game_state(a_state),
    .o_score(a_score), .o_high_score(a_high),
    .o_game_over_pulse(a_pulse), .o_new_high_score(a_nh)
  );

  game_controller #(
    .GAME_LENGTH_SECONDS(GLS), .CLKS_PER_MS(CPM), .READY_MS(RMS),
    .MAX_SCORE(MAXS), .MISS_PENALTY(0)
  ) dut_b (
    .clk(clk), .rst(rst), .i_start_btn(start_btn), .i_pause_btn(pause_btn),
    .i_hit_pulse(hit), .i_miss_pulse(miss), .i_time_ms(time_ms),
    .o_timer_rst(b_trst), .o_timer_enable(b_ten), .o_game_state(b_state),
    .o_score(b_score), .o_high_score(b_high),
    .o_game_over_pulse(b_pulse), .o_new_high_score(b_nh)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  game_state_t m_state;
  int          m_score_a, m_score_b, m_hi_a, m_hi_b;
  bit          m_nh_a, m_nh_b, m_pulse;
  int          tms;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int apply_play(input int s, input bit h, input bit m, input bit pen);
    if (h && !m) return (s < MAXS) ? s + 1 : MAXS;
    if (m && !h && pen) return (s > 0) ? s - 1 : 0;
    return s;
  endfunction

  task automatic check_all(input string tag);
    bit exp_trst, exp_en;
    exp_trst = (m_state == IDLE) || (m_state == READY) || (m_state == OVER);
    exp_en   = (m_state == PLAY);
    check({tag, ".a_state"}, 32'(a_state), 32'(m_state));
    check({tag, ".a_trst"},  32'(a_trst),  32'(exp_trst));
    check({tag, ".a_ten"},   32'(a_ten),   32'(exp_en));
    check({tag, ".a_score"}, 32'(a_score), 32'(m_score_a));
    check({tag, ".a_high"},  32'(a_high),  32'(m_hi_a));
    check({tag, ".a_pulse"}, 32'(a_pulse), 32'(m_pulse));
    check({tag, ".a_nh"},    32'(a_nh),    32'(m_nh_a));
    check({tag, ".b_state"}, 32'(b_state), 32'(m_state));
    check({tag, ".b_ten"},   32'(b_ten),   32'(exp_en));
    check({tag, ".b_score"}, 32'(b_score), 32'(m_score_b));
    check({tag, ".b_high"},  32'(b_high),  32'(m_hi_b));
    check({tag, ".b_pulse"}, 32'(b_pulse), 32'(m_pulse));
    check({tag, ".b_nh"},    32'(b_nh),    32'(m_nh_b));
  endtask

  // Drive one cycle of inputs, advance the model by the game rules and the
  // expected next state, then compare every output.
  task automatic step(input string tag, input bit s, input bit p, input bit h,
                      input bit m, input game_state_t nxt);
    game_state_t cur;
    cur       = m_state;
    start_btn = s;
    pause_btn = p;
    hit       = h;
    miss      = m;
    time_ms   = TW'(tms);
    tick();
    if (cur == PLAY) begin
      m_score_a = apply_play(m_score_a, h, m, 1'b1);
      m_score_b = apply_play(m_score_b, h, m, 1'b0);
    end
    if (nxt == READY && cur != READY) begin
      m_score_a = 0;
      m_score_b = 0;
    end
    m_pulse = (cur == PLAY) && (nxt == OVER);
    if (m_pulse) begin
      m_nh_a = (m_score_a > m_hi_a);
      m_nh_b = (m_score_b > m_hi_b);
      if (m_nh_a) m_hi_a = m_score_a;
      if (m_nh_b) m_hi_b = m_score_b;
    end else if (nxt != OVER) begin
      m_nh_a = 1'b0;
      m_nh_b = 1'b0;
    end
    m_state = nxt;
    case (nxt)
      PLAY:    tms = tms - 1;
      PAUSED:  tms = tms;
      default: tms = TMS_INIT;
    endcase
    check_all(tag);
  endtask

  task automatic do_reset(input int cycles);
    rst       = 1'b1;
    start_btn = 1'b0;
    pause_btn = 1'b0;
    hit       = 1'b0;
    miss      = 1'b0;
    time_ms   = TW'(TMS_INIT);
    for (int i = 0; i < cycles; i++) tick();
    m_state   = IDLE;
    m_score_a = 0;
    m_score_b = 0;
    m_hi_a    = 0;
    m_hi_b    = 0;
    m_nh_a    = 1'b0;
    m_nh_b    = 1'b0;
    m_pulse   = 1'b0;
    tms       = TMS_INIT;
    check_all("reset");
    rst = 1'b0;
  endtask

  // Start rise, READY_CYCLES-1 cycles of ignored random activity, then PLAY.
  task automatic run_ready(input string tag);
    step({tag, ".start"}, 1'b1, 1'b0, 1'b0, 1'b0, READY);
    for (int i = 0; i < READY_CYCLES - 1; i++)
      step({tag, ".ready"}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), READY);
    step({tag, ".to_play"}, 1'b0, 1'b0, 1'b0, 1'b0, PLAY);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset(3);

    // IDLE: pause does nothing; start at cycle 10.
    step("idle", 1'b0, 1'b1, 1'b0, 1'b0, IDLE);
    for (int i = 0; i < 5; i++) step("idle", 1'b0, 1'b0, 1'b1, 1'b1, IDLE);

    // Game 1
    run_ready("g1");
    for (int i = 0; i < 3; i++) step("g1.hit", 1'b0, 1'b0, 1'b1, 1'b0, PLAY);
    step("g1.miss",    1'b0, 1'b0, 1'b0, 1'b1, PLAY);
    step("g1.hitmiss", 1'b0, 1'b0, 1'b1, 1'b1, PLAY);
    check("mix_score_pen",   32'(a_score), 32'd2);
    check("mix_score_nopen", 32'(b_score), 32'd3);

    for (int i = 0; i < 9; i++) step("g1.sat", 1'b0, 1'b0, 1'b1, 1'b0, PLAY);
    check("saturate", 32'(a_score), 32'(MAXS));

    for (int i = 0; i < 10; i++) step("g1.floor", 1'b0, 1'b0, 1'b0, 1'b1, PLAY);
    check("floor_zero", 32'(a_score), 32'd0);

    step("g1.start_ign", 1'b1, 1'b0, 1'b0, 1'b0, PLAY);
    step("g1.start_rel", 1'b0, 1'b0, 1'b0, 1'b0, PLAY);

    for (int i = 0; i < 40; i++)
      step("g1.rand", 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), PLAY);

    // Pause / resume
    step("g1.pause",     1'b0, 1'b1, 1'b0, 1'b0, PAUSED);
    step("g1.p_hold",    1'b0, 1'b1, 1'b1, 1'b0, PAUSED);
    step("g1.p_miss",    1'b0, 1'b0, 1'b0, 1'b1, PAUSED);
    step("g1.p_hit",     1'b0, 1'b0, 1'b1, 1'b0, PAUSED);
    step("g1.resume",    1'b0, 1'b1, 1'b0, 1'b0, PLAY);
    step("g1.post_hit",  1'b0, 1'b0, 1'b1, 1'b0, PLAY);

    // Expiry with a hit on the same cycle
    tms = 0;
    step("g1.expire", 1'b0, 1'b0, 1'b1, 1'b0, OVER);
    check("g1_over_pulse", 32'(a_pulse), 32'd1);
    check("g1_new_high",   32'(a_nh),    32'd1);
    step("g1.over",       1'b0, 1'b0, 1'b0, 1'b0, OVER);
    step("g1.over_pause", 1'b0, 1'b1, 1'b1, 1'b0, OVER);
    step("g1.over",       1'b0, 1'b0, 1'b0, 1'b0, OVER);

    // Game 2: lower score, high score must hold
    run_ready("g2");
    step("g2.hit", 1'b0, 1'b0, 1'b1, 1'b0, PLAY);
    tms = 0;
    step("g2.expire", 1'b0, 1'b0, 1'b0, 1'b0, OVER);
    check("g2_no_new_high", 32'(a_nh), 32'd0);
    step("g2.over", 1'b0, 1'b0, 1'b0, 1'b0, OVER);

    // Game 3: abort from PAUSED with both buttons rising together
    run_ready("g3");
    step("g3.hit",   1'b0, 1'b0, 1'b1, 1'b0, PLAY);
    step("g3.hit",   1'b0, 1'b0, 1'b1, 1'b0, PLAY);
    step("g3.pause", 1'b0, 1'b1, 1'b0, 1'b0, PAUSED);
    step("g3.rel",   1'b0, 1'b0, 1'b0, 1'b0, PAUSED);
    step("g3.abort", 1'b1, 1'b1, 1'b0, 1'b0, IDLE);
    check("abort_keeps_score", 32'(a_score), 32'd2);
    step("g3.idle",  1'b0, 1'b0, 1'b0, 1'b0, IDLE);

    // Game 4: reset in the middle of play
    run_ready("g4");
    for (int i = 0; i < 3; i++) step("g4.hit", 1'b0, 1'b0, 1'b1, 1'b0, PLAY);
    do_reset(1);
    check("rst_clears_high", 32'(a_high), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
